// File: rtl/mul_issuer.sv
// mul_issuer: handshake initiator for the shift-add multiplier (start/count issue, result capture, timeout).
// Optional MUL_ISSUER_ZERO_SKIP_EN: zero operands bypass the multiplier and return 0 directly.
module mul_issuer #(
  parameter int DATA_W  = 4,
  parameter int RES_W   = 8,
  parameter int TIMEOUT = 15,
  parameter int TMO_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              start,
  output logic [2:0]        count,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  input  logic              locked,
  input  logic              done_flag,
  input  logic [RES_W-1:0]  product,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RES_W-1:0]  out_data,
  output logic              busy,
  output logic              timeout_err
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, HOLD, ERR} state_t;
  state_t state;
  logic [TMO_W-1:0] tmo;
  logic zero;
`ifdef MUL_ISSUER_ZERO_SKIP_EN
  assign zero = (in_a == '0) || (in_b == '0);
`else
  assign zero = 1'b0;
`endif
  assign in_ready = state == IDLE;
  assign busy = state != IDLE;
  // start is registered from the previous cycle's locked, so it pulses the cycle after the controller frees up
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      start <= 1'b0;
      count <= '0;
      op_a <= '0;
      op_b <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      timeout_err <= 1'b0;
      tmo <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          op_a <= in_a;
          op_b <= in_b;
          timeout_err <= 1'b0;
          count <= '0;
          tmo <= '0;
          if (zero) begin
            out_data <= '0;
            out_valid <= 1'b1;
            state <= HOLD;
          end else begin
            start <= !locked;
            state <= ISSUE;
          end
        end
        ISSUE: if (start) begin
          start <= 1'b0;
          count <= 3'd1;
          state <= WAIT;
        end else start <= !locked;
        WAIT: begin
          tmo <= tmo + 1'b1;
          count <= (count == 3'd5) ? 3'd5 : count + 3'd1;
          if (done_flag) begin
            out_data <= product;
            out_valid <= 1'b1;
            count <= '0;
            state <= HOLD;
          end else if (tmo == TMO_W'(TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            out_data <= '0;
            count <= '0;
            tmo <= '0;
            state <= ERR;
          end
        end
        HOLD: if (out_ready) begin
          out_valid <= 1'b0;
          state <= IDLE;
        end
        ERR: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mul_issuer.sv
// tb_mul_issuer: directed scoreboard bench for mul_issuer with a behavioural multiplier controller.
module tb_mul_issuer;
  logic clk, rst, in_valid, in_ready, start, locked, done_flag, out_valid, out_ready, busy, timeout_err;
  logic [3:0] in_a, in_b, op_a, op_b;
  logic [2:0] count;
  logic [7:0] product, out_data;
  logic force_locked, kill_done;
  int cst;
  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] sb[$];

  mul_issuer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .start(start), .count(count), .op_a(op_a), .op_b(op_b), .locked(locked), .done_flag(done_flag),
    .product(product), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .timeout_err(timeout_err)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // controller model: IDLE(0) -> S0..S3(1..4) -> FINISH(5) -> IDLE
  always @(posedge clk)
    if (!rst) cst <= 0;
    else if (cst == 0) cst <= start ? 1 : 0;
    else if (cst == 5) cst <= 0;
    else cst <= cst + 1;
  assign locked = (cst != 0) || force_locked;
  assign done_flag = (cst == 5) && !kill_done;
  assign product = {4'b0, op_a} * {4'b0, op_b};

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk)
    if (rst && out_valid && out_ready) begin
      if (sb.size() == 0) chk("sb_unexpected_out_valid", 1, 0);
      else chk("sb_out_data", int'(out_data), int'(sb.pop_front()));
    end

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [3:0] a, input logic [3:0] b);
    chk("in_ready_before_accept", int'(in_ready), 1);
    in_valid = 1; in_a = a; in_b = b;
    cyc;
    in_valid = 0;
  endtask

  task automatic wait_valid(input string nm);
    for (int i = 0; i < 40 && !out_valid; i++) cyc;
    chk(nm, int'(out_valid), 1);
  endtask

  initial begin
    rst = 0; in_valid = 0; in_a = 0; in_b = 0; out_ready = 1; force_locked = 0; kill_done = 0;
    cyc; cyc;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_start", int'(start), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_timeout_err", int'(timeout_err), 0);
    chk("rst_op_a", int'(op_a), 0);
    rst = 1;
    cyc;
    // nominal 3*5
    sb.push_back(8'd15);
    accept(4'd3, 4'd5);
    chk("t1_start_pulse", int'(start), 1);
    chk("t1_count_issue", int'(count), 0);
    for (int i = 1; i <= 5; i++) begin
      cyc;
      chk("t1_count_seq", int'(count), i);
      chk("t1_start_low", int'(start), 0);
    end
    cyc;
    chk("t1_out_valid_latency", int'(out_valid), 1);
    cyc;
    chk("t1_in_ready_after", int'(in_ready), 1);
    chk("t1_out_valid_drop", int'(out_valid), 0);
    // backpressure 15*15
    out_ready = 0;
    sb.push_back(8'd225);
    accept(4'd15, 4'd15);
    wait_valid("t2_out_valid");
    for (int i = 0; i < 4; i++) begin
      chk("t2_hold_valid", int'(out_valid), 1);
      chk("t2_hold_data", int'(out_data), 225);
      chk("t2_hold_in_ready", int'(in_ready), 0);
      cyc;
    end
    out_ready = 1;
    chk("t2_final_valid", int'(out_valid), 1);
    chk("t2_final_data", int'(out_data), 225);
    cyc;
    chk("t2_single_transfer", int'(out_valid), 0);
    // controller still locked across accept
    force_locked = 1;
    sb.push_back(8'd63);
    accept(4'd7, 4'd9);
    chk("t3_start_locked1", int'(start), 0);
    cyc;
    chk("t3_start_locked2", int'(start), 0);
    chk("t3_busy", int'(busy), 1);
    cyc;
    chk("t3_start_locked3", int'(start), 0);
    cyc;
    chk("t3_start_locked_fall", int'(start), 0);
    force_locked = 0;
    cyc;
    chk("t3_start_after_unlock", int'(start), 1);
    wait_valid("t3_out_valid");
    cyc;
    // timeout
    kill_done = 1;
    accept(4'd2, 4'd3);
    chk("t4_start", int'(start), 1);
    repeat (9) cyc;
    chk("t4_count_saturate", int'(count), 5);
    repeat (6) cyc;
    chk("t4_no_err_yet", int'(timeout_err), 0);
    chk("t4_busy_wait", int'(busy), 1);
    cyc;
    chk("t4_timeout_err", int'(timeout_err), 1);
    chk("t4_err_count", int'(count), 0);
    cyc;
    chk("t4_idle_in_ready", int'(in_ready), 1);
    chk("t4_err_sticky", int'(timeout_err), 1);
    chk("t4_no_out_valid", int'(out_valid), 0);
    kill_done = 0;
    repeat (3) cyc;
    chk("t4_err_still_sticky", int'(timeout_err), 1);
    // zero operand, clears sticky error
    sb.push_back(8'd0);
    accept(4'd0, 4'd9);
    chk("t5_err_cleared", int'(timeout_err), 0);
`ifdef MUL_ISSUER_ZERO_SKIP_EN
    chk("t5_skip_valid", int'(out_valid), 1);
    chk("t5_skip_no_start", int'(start), 0);
    chk("t5_skip_count", int'(count), 0);
    cyc;
`else
    chk("t5_zero_start", int'(start), 1);
    wait_valid("t5_out_valid");
    cyc;
`endif
    // reset mid-WAIT
    accept(4'd6, 4'd7);
    repeat (3) cyc;
    chk("t6_count_before_rst", int'(count), 3);
    rst = 0;
    cyc;
    chk("t6_rst_count", int'(count), 0);
    chk("t6_rst_out_valid", int'(out_valid), 0);
    chk("t6_rst_in_ready", int'(in_ready), 1);
    chk("t6_rst_busy", int'(busy), 0);
    chk("t6_rst_start", int'(start), 0);
    rst = 1;
    cyc;
    // recovery
    sb.push_back(8'd16);
    accept(4'd4, 4'd4);
    wait_valid("t7_out_valid");
    cyc; cyc;
    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
